pipeline_ctrl: RTL and testbench

Central sequencer for the 5-stage pipeline. It generates the per-stage `load` enables and bubble-insert (`flush`) strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB `register` instances. It resolves load-use stalls, taken-branch flushes, multi-cycle data-memory waits with timeout, and halt/resume. It also keeps saturating stall and flush performance counters.

---
 rtl/pipeline_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Central sequencer for the 5-stage pipeline. It drives the per-stage load
//   enables and the bubble-insert strobes for the PC, IF/ID, ID/EX, EX/MEM and
//   MEM/WB registers. It resolves:
//     - load-use stalls (one cycle),
//     - taken-branch flushes (two bubbles in one edge),
//     - multi-cycle data-memory waits, with a timeout that halts and sets mem_err,
//     - halt/resume.
//   It also keeps saturating stall and flush performance counters.
//
// Ports
//   clk, rst                : rising-edge clock, asynchronous active-low reset
//   idex_memread, idex_rd   : ID/EX instruction is a load, and its destination
//   ifid_rs1, ifid_rs2      : sources of the IF/ID instruction
//   branch_taken            : branch/jump resolved taken in EX
//   mem_req, mem_ready      : data-memory access in EX/MEM, and its completion
//   halt, resume            : halting instruction in MEM/WB, restart request
//   *_load                  : per-stage load enables (combinational)
//   ifid_flush, idex_flush  : load a bubble instead of D (combinational)
//   halted                  : controller is in the halted state
//   mem_err                 : sticky memory-timeout flag
//   stall_cnt, flush_cnt    : saturating performance counters
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int REGW     = 5,
  parameter int CNTW     = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            idex_memread,
  input  logic [REGW-1:0] idex_rd,
  input  logic [REGW-1:0] ifid_rs1,
  input  logic [REGW-1:0] ifid_rs2,
  input  logic            branch_taken,
  input  logic            mem_req,
  input  logic            mem_ready,
  input  logic            halt,
  input  logic            resume,
  output logic            pc_load,
  output logic            ifid_load,
  output logic            idex_load,
  output logic            exmem_load,
  output logic            memwb_load,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            halted,
  output logic            mem_err,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_HALTED,
    S_RESUME
  } state_t;

  state_t        state, state_next;
  logic [WW-1:0] wait_cnt, wait_next;
  logic          err_next;
  logic          stall_inc, flush_inc;
  logic          freeze, lu_hazard;

  // Bit order of the load vector: {pc, ifid, idex, exmem, memwb}.
  // Bit order of the flush vector: {ifid, idex}.
  logic [4:0]    loads;
  logic [1:0]    flushes;

  // Result of the RUN event evaluation. It is reused by MEM_WAIT once the
  // memory access completes.
  logic [4:0]    run_loads;
  logic [1:0]    run_flushes;
  state_t        run_state;
  logic          run_stall, run_flush;

  assign freeze    = mem_req & ~mem_ready;
  assign lu_hazard = idex_memread & (idex_rd != '0) &
                     ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

  // Event priority: freeze > halt > branch > load-use. A taken branch hides
  // any load-use hazard because the IF/ID instruction is wrong-path.
  always_comb begin
    run_loads   = 5'b11111;
    run_flushes = 2'b00;
    run_state   = S_RUN;
    run_stall   = 1'b0;
    run_flush   = 1'b0;
    if (freeze) begin
      run_loads = 5'b00000;
      run_state = S_MEM_WAIT;
      run_stall = 1'b1;
    end else if (halt) begin
      run_loads = 5'b00000;
      run_state = S_HALTED;
      run_stall = 1'b1;
    end else if (branch_taken) begin
      run_flushes = 2'b11;
      run_flush   = 1'b1;
    end else if (lu_hazard) begin
      // Hold PC and IF/ID, and push a bubble into ID/EX.
      run_loads   = 5'b00111;
      run_flushes = 2'b01;
      run_stall   = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    err_next   = mem_err;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    loads      = 5'b11111;
    flushes    = 2'b00;
    unique case (state)
      S_RUN: begin
        loads      = run_loads;
        flushes    = run_flushes;
        state_next = run_state;
        stall_inc  = run_stall;
        flush_inc  = run_flush;
        // The entry cycle counts as the first wait cycle.
        if (freeze) wait_next = WW'(1);
      end
      S_MEM_WAIT: begin
        if (freeze) begin
          loads     = 5'b00000;
          stall_inc = 1'b1;
          if (wait_cnt == LAST_WAIT) begin
            err_next   = 1'b1;
            state_next = S_HALTED;
          end else begin
            wait_next = wait_cnt + 1'b1;
          end
        end else begin
          loads      = run_loads;
          flushes    = run_flushes;
          state_next = run_state;
          stall_inc  = run_stall;
          flush_inc  = run_flush;
        end
      end
      S_HALTED: begin
        loads = 5'b00000;
        if (resume) state_next = S_RESUME;
      end
      S_RESUME: begin
        // halt is ignored here so the halting instruction can retire.
        if (freeze) begin
          loads      = 5'b00000;
          state_next = S_MEM_WAIT;
          wait_next  = WW'(1);
        end else begin
          state_next = S_RUN;
        end
      end
      default: state_next = S_RUN;
    endcase
  end

  // While reset is held every enable and strobe is forced low, independent of
  // the inputs.
  assign {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = rst ? loads : 5'b00000;
  assign {ifid_flush, idex_flush} = rst ? flushes : 2'b00;
  assign halted = (state == S_HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      mem_err  <= err_next;
      if (stall_inc && (stall_cnt != {CNTW{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != {CNTW{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int REGW     = 5;
  localparam int MAX_WAIT = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            idex_memread = 1'b0;
  logic [REGW-1:0] idex_rd = '0;
  logic [REGW-1:0] ifid_rs1 = '0;
  logic [REGW-1:0] ifid_rs2 = '0;
  logic            branch_taken = 1'b0;
  logic            mem_req = 1'b0;
  logic            mem_ready = 1'b0;
  logic            halt = 1'b0;
  logic            resume = 1'b0;

  logic pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic ifid_flush, idex_flush, halted, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  logic s_pc_load, s_ifid_load, s_idex_load, s_exmem_load, s_memwb_load;
  logic s_ifid_flush, s_idex_flush, s_halted, s_mem_err;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.REGW(REGW), .CNTW(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .halt(halt), .resume(resume),
    .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
    .exmem_load(exmem_load), .memwb_load(memwb_load),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy, driven identically, to exercise saturation.
  pipeline_ctrl #(.REGW(REGW), .CNTW(4), .MAX_WAIT(MAX_WAIT)) dut_s (
    .clk(clk), .rst(rst),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .halt(halt), .resume(resume),
    .pc_load(s_pc_load), .ifid_load(s_ifid_load), .idex_load(s_idex_load),
    .exmem_load(s_exmem_load), .memwb_load(s_memwb_load),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .halted(s_halted), .mem_err(s_mem_err),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Reference model: controller mode, frozen cycles in the current memory
  // episode, and unbounded event tallies.
  localparam int M_RUN = 0, M_WAIT = 1, M_HALTED = 2, M_RESUME = 3;
  int      m_mode = M_RUN, n_mode;
  int      m_frozen = 0, n_frozen;
  bit      m_err = 1'b0, n_err_flag;
  longint  m_stalls = 0, m_flushes = 0;
  bit      d_stall, d_flush;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_comb(output logic [4:0] eld, output logic [1:0] efl);
    bit frz, hz;
    frz = mem_req && !mem_ready;
    hz  = idex_memread && (idex_rd != 0) && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
    eld = 5'b11111; efl = 2'b00;
    n_mode = m_mode; n_frozen = m_frozen; n_err_flag = m_err;
    d_stall = 1'b0; d_flush = 1'b0;
    if (m_mode == M_HALTED) begin
      eld = 5'b00000;
      if (resume) n_mode = M_RESUME;
    end else if (m_mode == M_RESUME) begin
      if (frz) begin eld = 5'b00000; n_mode = M_WAIT; n_frozen = 1; end
      else n_mode = M_RUN;
    end else if (frz) begin
      eld = 5'b00000; d_stall = 1'b1;
      if (m_mode == M_RUN) begin
        n_mode = M_WAIT; n_frozen = 1;
      end else if (m_frozen + 1 >= MAX_WAIT) begin
        n_err_flag = 1'b1; n_mode = M_HALTED;
      end else begin
        n_frozen = m_frozen + 1;
      end
    end else begin
      n_mode = M_RUN;
      if (halt) begin eld = 5'b00000; d_stall = 1'b1; n_mode = M_HALTED; end
      else if (branch_taken) begin efl = 2'b11; d_flush = 1'b1; end
      else if (hz) begin eld = 5'b00111; efl = 2'b01; d_stall = 1'b1; end
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_frozen = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0;
  endtask

  // One clock cycle: inputs are already applied; check combinational outputs,
  // take the edge, then check registered outputs.
  task automatic step();
    logic [4:0] eld;
    logic [1:0] efl;
    model_comb(eld, efl);
    #1;
    chk("loads", {pc_load, ifid_load, idex_load, exmem_load, memwb_load}, eld);
    chk("flushes", {ifid_flush, idex_flush}, efl);
    chk("loads_s", {s_pc_load, s_ifid_load, s_idex_load, s_exmem_load, s_memwb_load}, eld);
    @(posedge clk);
    m_mode = n_mode; m_frozen = n_frozen; m_err = n_err_flag;
    m_stalls += d_stall; m_flushes += d_flush;
    #1;
    chk("halted", halted, m_mode == M_HALTED);
    chk("mem_err", mem_err, m_err);
    chk("stall_cnt", stall_cnt, m_stalls);
    chk("flush_cnt", flush_cnt, m_flushes);
    chk("stall_cnt_sat", s_stall_cnt, (m_stalls > 15) ? 15 : m_stalls);
    chk("flush_cnt_sat", s_flush_cnt, (m_flushes > 15) ? 15 : m_flushes);
    $display("t=%0t mode=%0d ld=%b fl=%b stall=%0d flush=%0d err=%0d",
             $time, m_mode, eld, efl, stall_cnt, flush_cnt, mem_err);
  endtask

  task automatic quiet();
    idex_memread = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0; halt = 0; resume = 0;
  endtask

  longint base;

  initial begin
    // Reset state
    #2;
    chk("rst_loads", {pc_load, ifid_load, idex_load, exmem_load, memwb_load}, 5'b00000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_stall", stall_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    step();  // idle RUN: all loads 1

    // Load-use hazard
    idex_memread = 1; idex_rd = 5; ifid_rs2 = 5;
    step();
    chk("lu_stall_cnt", stall_cnt, 1);
    // Same with rd=0: no stall
    idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
    step();
    chk("lu_rd0_stall_cnt", stall_cnt, 1);

    // Branch plus hazard
    quiet(); idex_memread = 1; idex_rd = 7; ifid_rs1 = 7; branch_taken = 1;
    step();
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 1);

    // Memory wait: 3 frozen cycles then ready
    quiet(); mem_req = 1; mem_ready = 0;
    base = stall_cnt;
    for (int i = 0; i < 3; i++) step();
    mem_ready = 1;
    step();
    chk("memwait_stalls", stall_cnt - base, 3);

    // Memory timeout
    quiet(); mem_req = 1; mem_ready = 0;
    for (int i = 0; i < MAX_WAIT - 1; i++) step();
    chk("timeout_early_err", mem_err, 1'b0);
    step();
    chk("timeout_err", mem_err, 1'b1);
    chk("timeout_halted", halted, 1'b1);
    resume = 1; mem_ready = 1;
    step();   // HALTED -> RESUME
    resume = 0;
    step();   // RESUME retires, back to RUN
    quiet();
    step();
    chk("timeout_back_run", {pc_load, halted}, 2'b10);

    // Halt / resume
    halt = 1;
    step();
    base = stall_cnt;
    for (int i = 0; i < 3; i++) step();
    chk("halt_counters_frozen", stall_cnt, base);
    resume = 1;
    step();
    resume = 0;
    step();   // single RESUME cycle with halt still 1
    halt = 0;
    step();

    // Reset mid-MEM_WAIT
    mem_req = 1; mem_ready = 0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rstmid_loads", {pc_load, ifid_load, idex_load, exmem_load, memwb_load}, 5'b00000);
    chk("rstmid_stall", stall_cnt, 0);
    chk("rstmid_err", mem_err, 1'b0);
    model_reset();
    quiet();
    #3 rst = 1'b1;
    @(posedge clk); #1;
    step();

    // Saturation on the narrow instance
    idex_memread = 1; idex_rd = 3; ifid_rs1 = 3;
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall", s_stall_cnt, 4'd15);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      idex_memread = ($urandom_range(0, 1) == 1);
      idex_rd      = REGW'($urandom_range(0, 3));
      ifid_rs1     = REGW'($urandom_range(0, 3));
      ifid_rs2     = REGW'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 4) == 0);
      mem_req      = ($urandom_range(0, 9) < 3);
      mem_ready    = ($urandom_range(0, 9) < 6);
      halt         = ($urandom_range(0, 19) == 0);
      resume       = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
